// File: rtl/joycon_port_ctrl.sv
// Serial game-controller port block: CPU strobe write latches button snapshots, reads shift them out one bit per access.
// Read data is combinational; state advances on the clock edge after the first cycle of each read access. No backpressure.
module joycon_port_ctrl #(
    parameter logic [15:0] BASE_ADDR      = 16'h4016,
    parameter int          NUM_PORTS      = 2,
    parameter int          BITS_PER_PORT  = 8,
    parameter logic        FILL_BIT       = 1'b1,
    parameter logic [7:0]  OPEN_BUS       = 8'h40,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter logic [15:0] TURBO_HALF     = 16'd2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [15:0]                        cpu_addr,
    input  logic [7:0]                         cpu_wdata,
    input  logic                               cpu_write_en,
    input  logic                               cpu_read_en,
    output logic [7:0]                         cpu_rdata,
    output logic                               cpu_rd_hit,
    input  logic [NUM_PORTS*BITS_PER_PORT-1:0] btn_in,
    input  logic [NUM_PORTS*2-1:0]             turbo_en
);
    localparam int             CW       = $clog2(BITS_PER_PORT + 1);
    localparam int             NB       = NUM_PORTS * BITS_PER_PORT;
    localparam logic [CW-1:0]  CNT_FULL = CW'(BITS_PER_PORT);

    logic                     r_strobe;
    logic [BITS_PER_PORT-1:0] r_sr  [NUM_PORTS];
    logic [CW-1:0]            r_cnt [NUM_PORTS];
    logic [15:0]              r_turbo_cnt;
    logic                     r_turbo_phase;
    logic                     r_prev_hit;
    logic                     r_prev_port;

    logic [NB-1:0]            w_press;
    logic [NB-1:0]            w_masked;
    logic [NUM_PORTS-1:0]     w_adv;
    logic                     w_wr_hit;
    logic                     w_hit;
    logic                     w_port;
    logic                     w_bit;
    logic                     w_unused_wdata;

    assign w_press        = BTN_ACTIVE_LOW ? ~btn_in : btn_in;
    assign w_wr_hit       = cpu_write_en && (cpu_addr == BASE_ADDR);
    assign w_unused_wdata = ^cpu_wdata[7:1];

    // Turbo suppresses A/B during the low half of the turbo phase.
    always_comb begin
        w_masked = w_press;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (turbo_en[2*p] && !r_turbo_phase)
                w_masked[p*BITS_PER_PORT] = 1'b0;
            if (turbo_en[2*p+1] && !r_turbo_phase)
                w_masked[p*BITS_PER_PORT+1] = 1'b0;
        end
    end

    // A hit held at the same port is one access; a colliding strobe write blocks the advance.
    always_comb begin
        w_adv  = '0;
        w_hit  = 1'b0;
        w_port = 1'b0;
        w_bit  = FILL_BIT;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (cpu_read_en && (cpu_addr == BASE_ADDR + 16'(p))) begin
                w_hit  = 1'b1;
                w_port = 1'(p);
                if (r_cnt[p] < CNT_FULL)
                    w_bit = r_sr[p][0];
                w_adv[p] = !w_wr_hit && !(r_prev_hit && (r_prev_port == 1'(p)));
            end
        end
    end

    assign cpu_rd_hit = w_hit;
    assign cpu_rdata  = w_hit ? (OPEN_BUS | {7'b0, w_bit}) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_turbo_cnt   <= 16'd0;
            r_turbo_phase <= 1'b0;
        end else if (r_turbo_cnt == TURBO_HALF - 16'd1) begin
            r_turbo_cnt   <= 16'd0;
            r_turbo_phase <= ~r_turbo_phase;
        end else begin
            r_turbo_cnt   <= r_turbo_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe    <= 1'b0;
            r_prev_hit  <= 1'b0;
            r_prev_port <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_sr[p]  <= {BITS_PER_PORT{FILL_BIT}};
                r_cnt[p] <= CNT_FULL;
            end
        end else begin
            if (w_wr_hit)
                r_strobe <= cpu_wdata[0];
            r_prev_hit  <= w_hit;
            r_prev_port <= w_port;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (r_strobe) begin
                    r_sr[p]  <= w_masked[p*BITS_PER_PORT +: BITS_PER_PORT];
                    r_cnt[p] <= '0;
                end else if (w_adv[p]) begin
                    r_sr[p] <= {FILL_BIT, r_sr[p][BITS_PER_PORT-1:1]};
                    if (r_cnt[p] != CNT_FULL)
                        r_cnt[p] <= r_cnt[p] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_joycon_port_ctrl.sv
// Bench for joycon_port_ctrl: directed scenarios plus random traffic against a snapshot/index reference model.
module tb_joycon_port_ctrl;
    localparam int NP = 2;
    localparam int NB = 8;
    localparam int TH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_write_en = 1'b0;
    logic        cpu_read_en = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rd_hit;
    logic [15:0] btn_in = 16'hFFFF;
    logic [3:0]  turbo_en = 4'h0;

    joycon_port_ctrl dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
        .cpu_rdata(cpu_rdata), .cpu_rd_hit(cpu_rd_hit),
        .btn_in(btn_in), .turbo_en(turbo_en)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic hit; logic [7:0] dat; } exp_t;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    string tag = "reset";

    // Reference model: per-port snapshot array plus read index.
    bit m_snap [NP][NB];
    int m_idx  [NP];
    bit m_strobe;
    bit m_prev_hit;
    int m_prev_port;
    int m_edges;

    function automatic bit press_now(int p, int b);
        bit pr;
        bit phase;
        pr    = ~btn_in[p*NB + b];
        phase = ((m_edges / TH) % 2) == 1;
        if (b < 2 && turbo_en[p*2 + b] && !phase) pr = 1'b0;
        return pr;
    endfunction

    function automatic int rd_port();
        if (cpu_read_en && cpu_addr >= 16'h4016 && cpu_addr < 16'h4016 + NP)
            return int'(cpu_addr - 16'h4016);
        return -1;
    endfunction

    function automatic exp_t model_read();
        exp_t e;
        int p;
        p = rd_port();
        e.hit = (p >= 0);
        e.dat = 8'h00;
        if (p >= 0)
            e.dat = 8'h40 | ((m_idx[p] < NB) ? {7'b0, m_snap[p][m_idx[p]]} : 8'h01);
        return e;
    endfunction

    task automatic model_reset();
        m_strobe = 0; m_prev_hit = 0; m_prev_port = 0; m_edges = 0;
        for (int p = 0; p < NP; p++) begin
            m_idx[p] = NB;
            for (int b = 0; b < NB; b++) m_snap[p][b] = 1'b1;
        end
    endtask

    task automatic model_edge();
        int  p;
        bit  wr;
        p  = rd_port();
        wr = cpu_write_en && cpu_addr == 16'h4016;
        if (m_strobe) begin
            for (int q = 0; q < NP; q++) begin
                for (int b = 0; b < NB; b++) m_snap[q][b] = press_now(q, b);
                m_idx[q] = 0;
            end
        end else if (p >= 0 && !wr && !(m_prev_hit && m_prev_port == p)) begin
            if (m_idx[p] < NB) m_idx[p]++;
        end
        if (wr) m_strobe = cpu_wdata[0];
        m_prev_hit  = (p >= 0);
        m_prev_port = (p >= 0) ? p : 0;
        m_edges++;
    endtask

    // One bus cycle: drive just after the edge, record expectation, advance model at the edge.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input bit w, input bit r);
        cpu_addr = a; cpu_wdata = d; cpu_write_en = w; cpu_read_en = r;
        if (r) exp_q.push_back(model_read());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0000, 8'h00, 0, 0);
    endtask

    task automatic strobe_pulse();
        step(16'h4016, 8'h01, 1, 0);
        step(16'h4016, 8'h00, 1, 0);
    endtask

    task automatic do_reset();
        cpu_write_en = 0; cpu_read_en = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!rst && cpu_read_en) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s: unexpected read, got hit=%0b data=%h, required no pending read", tag, cpu_rd_hit, cpu_rdata);
            end else begin
                e = exp_q.pop_front();
                if (cpu_rd_hit === e.hit && cpu_rdata === e.dat)
                    n_pass++;
                else
                    $display("FAIL %s: addr=%h got hit=%0b data=%h, required hit=%0b data=%h",
                             tag, cpu_addr, cpu_rd_hit, cpu_rdata, e.hit, e.dat);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        do_reset();

        tag = "reset_read";
        step(16'h4016, 8'h00, 0, 1);
        step(16'h4017, 8'h00, 0, 1);
        idle(1);

        tag = "basic_report";
        btn_in = 16'hFFFE;
        strobe_pulse();
        for (int i = 0; i < 10; i++) begin
            step(16'h4016, 8'h00, 0, 1);
            idle(1);
        end

        tag = "strobe_held";
        step(16'h4016, 8'h01, 1, 0);
        for (int i = 0; i < 3; i++) begin
            btn_in[0] = btn_in[0] ^ 1'b1;
            idle(1);
            step(16'h4016, 8'h00, 0, 1);
        end
        step(16'h4016, 8'h00, 1, 0);
        step(16'h4016, 8'h00, 0, 1);
        idle(1);

        tag = "held_read";
        btn_in = 16'hFFFD;
        strobe_pulse();
        for (int i = 0; i < 4; i++) step(16'h4016, 8'h00, 0, 1);
        idle(1);
        step(16'h4016, 8'h00, 0, 1);
        idle(1);

        tag = "two_ports";
        btn_in = 16'h7FFE;
        strobe_pulse();
        for (int i = 0; i < 9; i++) begin
            step(16'h4016, 8'h00, 0, 1);
            step(16'h4017, 8'h00, 0, 1);
        end
        step(16'h4018, 8'h00, 0, 1);
        idle(1);

        tag = "collision";
        btn_in = 16'hFFFA;
        strobe_pulse();
        step(16'h4016, 8'h00, 1, 1);
        idle(1);
        step(16'h4016, 8'h00, 0, 1);
        idle(1);
        step(16'h4016, 8'h00, 0, 1);
        idle(1);
        step(16'h4017, 8'h01, 1, 0);
        step(16'h4016, 8'h00, 0, 1);

        tag = "reset_mid_report";
        strobe_pulse();
        for (int i = 0; i < 3; i++) begin
            step(16'h4016, 8'h00, 0, 1);
            idle(1);
        end
        do_reset();
        step(16'h4016, 8'h00, 0, 1);
        idle(1);

        tag = "turbo";
        btn_in = 16'hFFFE;
        turbo_en = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step(16'h4016, 8'h01, 1, 0);
            idle(k % 3);
            step(16'h4016, 8'h00, 1, 0);
            step(16'h4016, 8'h00, 0, 1);
            idle(1);
        end
        turbo_en = 4'h0;

        tag = "random";
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            int sel;
            if (i % 50 == 0) btn_in = 16'($urandom);
            if (i % 97 == 0) turbo_en = 4'($urandom);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = 16'h4016;
                4, 5, 6:    a = 16'h4017;
                7:          a = 16'h4018;
                default:    a = 16'($urandom);
            endcase
            step(a, 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
        end

        tag = "drain";
        idle(3);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending expectations %0d, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
